// File: rtl/tick_gen.sv
// tick_gen: multi-channel clock divider with run, single-step and burst control.
// All channels share one enable; channel 0 paces step and burst operations.
module tick_gen #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic               step,
  input  logic [1:0]         mode,
  input  logic [NCH*CNT_W-1:0] div,
  input  logic [CNT_W-1:0]   burst_len,
  output logic [NCH-1:0]     clk_out,
  output logic [NCH-1:0]     tick,
  output logic               busy,
  output logic               burst_done
);

  typedef enum logic [1:0] {
    M_STOP  = 2'b00,
    M_RUN   = 2'b01,
    M_STEP  = 2'b10,
    M_BURST = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_STEP  = 2'b01,
    S_BURST = 2'b10
  } state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  mode_e            w_mode;
  state_e           r_state;
  logic [CNT_W-1:0] r_cnt [NCH];
  logic [CNT_W-1:0] w_div [NCH];
  logic [NCH-1:0]   w_wrap;
  logic [NCH-1:0]   r_clk_out;
  logic [NCH-1:0]   r_tick;
  logic [CNT_W-1:0] r_rem;
  logic             r_step_q;
  logic             r_go_q;
  logic             r_done;
  logic             w_step_rise;
  logic             w_go_rise;
  logic             w_busy;
  logic             w_abort;
  logic             w_en;
  logic             w_rise0;

  assign w_mode      = mode_e'(mode);
  assign w_step_rise = step & ~r_step_q;
  assign w_go_rise   = go & ~r_go_q;
  assign w_busy      = (r_state != S_IDLE);

  // A wrap uses >= so a divide value lowered below the count
  // still wraps on the next enabled cycle instead of overflowing.
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    assign w_div[k]  = div[k*CNT_W +: CNT_W];
    assign w_wrap[k] = (r_cnt[k] >= w_div[k]);
  end

  // Leaving the mode that started an operation aborts it.
  always_comb begin
    w_abort = 1'b0;
    unique case (r_state)
      S_STEP:  w_abort = (w_mode != M_STEP);
      S_BURST: w_abort = (w_mode != M_BURST);
      default: w_abort = 1'b0;
    endcase
  end

  // Common enable; an aborting cycle holds every channel.
  always_comb begin
    w_en = 1'b0;
    unique case (w_mode)
      M_STOP:  w_en = 1'b0;
      M_RUN:   w_en = go;
      M_STEP,
      M_BURST: w_en = w_busy & ~w_abort;
    endcase
  end

  assign w_rise0 = w_en & w_wrap[0] & ~r_clk_out[0];

  // Per-channel counters, divided clocks and rising-edge ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_cnt[k] <= '0;
      end
      r_clk_out <= '0;
      r_tick    <= '0;
    end else begin
      r_tick <= '0;
      if (w_en) begin
        for (int k = 0; k < NCH; k++) begin
          if (w_wrap[k]) begin
            r_cnt[k]     <= '0;
            r_clk_out[k] <= ~r_clk_out[k];
            r_tick[k]    <= ~r_clk_out[k];
          end else begin
            r_cnt[k] <= r_cnt[k] + ONE;
          end
        end
      end
    end
  end

  // Step/burst control FSM with edge detectors and burst counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rem    <= '0;
      r_done   <= 1'b0;
      r_step_q <= 1'b0;
      r_go_q   <= 1'b0;
    end else begin
      r_step_q <= step;
      r_go_q   <= go;
      r_done   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_mode == M_STEP && w_step_rise) begin
            r_state <= S_STEP;
          end else if (w_mode == M_BURST && w_go_rise) begin
            if (burst_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_rem   <= burst_len;
              r_state <= S_BURST;
            end
          end
        end
        S_STEP: begin
          if (w_abort || w_rise0) begin
            r_state <= S_IDLE;
          end
        end
        S_BURST: begin
          if (w_abort) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
          end else if (w_rise0) begin
            r_rem <= r_rem - ONE;
            if (r_rem == ONE) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign clk_out    = r_clk_out;
  assign tick       = r_tick;
  assign busy       = w_busy;
  assign burst_done = r_done;

endmodule

// File: doc/tick_gen.md
TICK_GEN -- requirements
Module: tick_gen

Interface
REQ-001 Parameter NCH, default 4, number of output clock channels (1..16).
REQ-002 Parameter CNT_W, default 16, width of each divide value and of burst_len.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 go  input  1  level enable in RUN mode; rising edge launches a burst in BURST mode.
REQ-006 step  input  1  rising edge requests one tick in STEP mode.
REQ-007 mode  input  2  00 STOP, 01 RUN, 10 STEP, 11 BURST.
REQ-008 div  input  NCH*CNT_W  per-channel half-period minus one; channel k uses bits [k*CNT_W +: CNT_W].
REQ-009 burst_len  input  CNT_W  number of channel-0 ticks per burst.
REQ-010 clk_out  output  NCH  registered divided clocks.
REQ-011 tick  output  NCH  registered one-cycle pulse, high in the cycle clk_out[k] is first 1.
REQ-012 busy  output  1  high while a step or burst is in progress.
REQ-013 burst_done  output  1  one-cycle pulse when a burst finishes.

Function
REQ-014 The block SHALL keep, per channel, a CNT_W-bit counter cnt[k] and a clk_out[k] register.
REQ-015 The block SHALL derive a common enable en: RUN gives en=go; STEP and BURST give en=busy; STOP gives en=0.
REQ-016 With en=1 and cnt[k] >= div[k], the block SHALL clear cnt[k] to 0 and toggle clk_out[k]; with en=1 otherwise, it SHALL increment cnt[k].
REQ-017 With en=0, cnt[k] and clk_out[k] SHALL hold.
REQ-018 The half period SHALL be div[k]+1 cycles; div[k]=0 SHALL give a period of 2 cycles.
REQ-019 A div[k] change below the current cnt[k] SHALL cause a wrap and toggle on the next enabled cycle, with no counter overflow.
REQ-020 tick[k] SHALL be 1 exactly in the cycle after the edge where clk_out[k] goes 0->1, and 0 in every other cycle.
REQ-021 step and go SHALL be rising-edge detected against a registered copy, and each registered copy SHALL reset to 0.
REQ-022 In STEP mode, a step rising edge while busy=0 SHALL set busy=1 on the next edge.
REQ-023 A STEP operation SHALL clear busy on the same edge where clk_out[0] goes 0->1.
REQ-024 In BURST mode, a go rising edge while busy=0 SHALL load a remaining-count register with burst_len and set busy=1.
REQ-025 With burst_len=0, no busy assertion SHALL occur, and burst_done SHALL pulse on the next edge.
REQ-026 During a burst, each clk_out[0] 0->1 edge SHALL decrement the remaining count.
REQ-027 The edge taking the remaining count 1->0 SHALL clear busy and set burst_done for one cycle.
REQ-028 step or go rising edges arriving while busy=1 SHALL be ignored.
REQ-029 A mode change while busy=1 SHALL abort the operation: busy->0 on the next edge, no burst_done, counters and clk_out hold their values.
REQ-030 A step edge in a mode other than STEP, and a go edge in a mode other than BURST, SHALL have no effect beyond REQ-015.

Reset
REQ-031 With rst_n=0 at a clk edge, the block SHALL set every cnt[k]=0, clk_out=0, tick=0, busy=0, burst_done=0, remaining count=0, and edge registers=0; rst_n=0 overrides all other inputs.
REQ-032 Reset asserted mid-step or mid-burst SHALL abort the operation without any burst_done pulse.
REQ-033 With go=1 held through reset release in BURST mode, the block SHALL detect a rising edge on the first cycle after release.

Verification
REQ-034 RUN mode, go=1, div[0]=0, div[1]=3 -> clk_out[0] toggles every cycle, tick[0] every 2 cycles; clk_out[1] has period 8, tick[1] every 8 cycles.
REQ-035 STEP mode, div[0]=1, clk_out[0]=0, one step pulse -> busy high for 2 cycles, tick[0] once, then everything holds; a second step pulse while busy is ignored.
REQ-036 BURST mode, div[0]=0, burst_len=3, go pulse -> exactly 3 tick[0] pulses, burst_done 1 cycle, busy 0 afterwards; burst_len=0 -> burst_done only, no ticks.
REQ-037 RUN mode, div[0]=9, change div[0] to 2 when cnt[0]=7 -> toggle on the next cycle, then period 6.
REQ-038 rst_n=0 mid-burst, then mode changed to STOP mid-step -> all outputs reach the REQ-031 values and busy=0 respectively, with no burst_done pulse.
